// File: rtl/aes192_cbc_seq.sv
// aes192_cbc_seq: CBC chaining sequencer placed directly in front of aes192_core.
// Owns the key/IV session and turns a valid/ready block stream into core key_en/din_en pulses.
module aes192_cbc_seq #(
    parameter int unsigned KEY_TMO = 255
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_key_load,
    input  logic [191:0] i_key,
    input  logic [127:0] i_iv,
    input  logic         i_mode,
    input  logic [127:0] i_din,
    input  logic         i_din_vld,
    output logic         o_din_rdy,
    output logic [127:0] o_dout,
    output logic         o_dout_vld,
    input  logic         i_dout_rdy,
    output logic         o_core_flag,
    output logic [191:0] o_core_key,
    output logic         o_core_key_en,
    output logic [127:0] o_core_din,
    output logic         o_core_din_en,
    input  logic [127:0] i_core_dout,
    input  logic         i_core_dout_en,
    input  logic         i_core_key_ok,
    output logic         o_busy,
    output logic         o_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEY   = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_CORE  = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    localparam int unsigned TW = (KEY_TMO < 4) ? 2 : $clog2(KEY_TMO + 1);
    // Counter is 0 on the key_en cycle, so key_ok is first honoured three cycles later.
    localparam logic [TW-1:0] GUARD   = TW'(3);
    localparam logic [TW-1:0] TMO_MAX = TW'(KEY_TMO);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [127:0]  chain;
    logic [127:0]  ct_hold;
    logic [127:0]  result;
    logic          key_ok_seen;
    logic          tmo_hit;
    logic          in_accept;
    logic          core_done;

    always_comb begin
        key_ok_seen = (state == ST_KEY) && (tmo_cnt >= GUARD) && i_core_key_ok;
        tmo_hit     = (state == ST_KEY) && !key_ok_seen && (tmo_cnt == TMO_MAX);
        in_accept   = (state == ST_READY) && i_din_vld;
        core_done   = (state == ST_CORE) && i_core_dout_en;
        // Decrypt removes the previous ciphertext (or IV) after the core.
        result      = o_core_flag ? i_core_dout : (i_core_dout ^ chain);
    end

    always_comb begin
        state_nxt = state;
        if (i_key_load) begin
            state_nxt = ST_KEY;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_KEY: begin
                    if (key_ok_seen) begin
                        state_nxt = ST_READY;
                    end else if (tmo_hit) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_READY: if (in_accept) state_nxt = ST_CORE;
                ST_CORE:  if (core_done) state_nxt = ST_OUT;
                ST_OUT:   if (i_dout_rdy) state_nxt = ST_READY;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_din_rdy = (state == ST_READY);
    assign o_busy    = (state != ST_IDLE) && (state != ST_READY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_cnt       <= '0;
            chain         <= '0;
            ct_hold       <= '0;
            o_core_flag   <= 1'b0;
            o_core_key    <= '0;
            o_core_key_en <= 1'b0;
            o_core_din    <= '0;
            o_core_din_en <= 1'b0;
            o_dout        <= '0;
            o_dout_vld    <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_core_key_en <= 1'b0;
            o_core_din_en <= 1'b0;
            if (i_key_load) begin
                tmo_cnt       <= '0;
                chain         <= i_iv;
                o_core_flag   <= i_mode;
                o_core_key    <= i_key;
                o_core_key_en <= 1'b1;
                o_dout_vld    <= 1'b0;
                o_err         <= 1'b0;
            end else begin
                if (state == ST_KEY) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                if (tmo_hit) begin
                    o_err <= 1'b1;
                end
                if (in_accept) begin
                    o_core_din    <= o_core_flag ? (i_din ^ chain) : i_din;
                    o_core_din_en <= 1'b1;
                    if (!o_core_flag) begin
                        ct_hold <= i_din;
                    end
                end
                if (core_done) begin
                    o_dout     <= result;
                    o_dout_vld <= 1'b1;
                    chain      <= o_core_flag ? i_core_dout : ct_hold;
                end
                if ((state == ST_OUT) && i_dout_rdy) begin
                    o_dout_vld <= 1'b0;
                end
                // A result strobe with no block in flight is a core protocol fault.
                if (i_core_dout_en && (state != ST_CORE)) begin
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes192_cbc_seq.sv
// tb_aes192_cbc_seq: scoreboard bench for aes192_cbc_seq with a behavioural core stand-in
// that knows the AES-192 vector pair for the test key and uses a toy mapping elsewhere.
module tb_aes192_cbc_seq;

    localparam int unsigned KEY_TMO  = 40;
    localparam int          KEY_LAT  = 10;
    localparam int          CORE_LAT = 5;

    localparam logic [191:0] KEY  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT2  = 128'hddb85e97c219b997e636da1b20d09f6e;
    localparam logic [127:0] MASK = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [191:0] key;
    logic [127:0] iv;
    logic         mode;
    logic [127:0] din;
    logic         din_vld;
    logic         din_rdy;
    logic [127:0] dout;
    logic         dout_vld;
    logic         dout_rdy;
    logic         core_flag;
    logic [191:0] core_key;
    logic         core_key_en;
    logic [127:0] core_din;
    logic         core_din_en;
    logic [127:0] core_dout;
    logic         core_dout_en;
    logic         core_key_ok;
    logic         busy;
    logic         err;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q[$];
    logic         key_ok_en;

    always #5 clk = ~clk;

    aes192_cbc_seq #(.KEY_TMO(KEY_TMO)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_key_load     (key_load),
        .i_key          (key),
        .i_iv           (iv),
        .i_mode         (mode),
        .i_din          (din),
        .i_din_vld      (din_vld),
        .o_din_rdy      (din_rdy),
        .o_dout         (dout),
        .o_dout_vld     (dout_vld),
        .i_dout_rdy     (dout_rdy),
        .o_core_flag    (core_flag),
        .o_core_key     (core_key),
        .o_core_key_en  (core_key_en),
        .o_core_din     (core_din),
        .o_core_din_en  (core_din_en),
        .i_core_dout    (core_dout),
        .i_core_dout_en (core_dout_en),
        .i_core_key_ok  (core_key_ok),
        .o_busy         (busy),
        .o_err          (err)
    );

    // Core stand-in: key_ok KEY_LAT cycles after key_en, result CORE_LAT cycles after din_en.
    int           kcnt = 0;
    int           pend = 0;
    logic [127:0] cdin;
    logic         cflag;
    always @(posedge clk) begin
        #1;
        core_dout_en = 1'b0;
        if (!rst_n) begin
            kcnt        = 0;
            pend        = 0;
            core_key_ok = 1'b0;
        end else begin
            if (core_key_en) begin
                core_key_ok = 1'b0;
                kcnt        = KEY_LAT;
            end else if (kcnt > 0) begin
                kcnt--;
                if (kcnt == 0) core_key_ok = key_ok_en;
            end
            if (core_din_en) begin
                pend  = CORE_LAT;
                cdin  = core_din;
                cflag = core_flag;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    core_dout_en = 1'b1;
                    if (cflag) core_dout = (cdin == PT) ? CT : (cdin ^ MASK);
                    else       core_dout = (cdin == CT) ? PT : (cdin ^ MASK);
                end
            end
        end
    end

    // Monitor: one comparison per output handshake.
    always @(negedge clk) begin
        if (rst_n && dout_vld && dout_rdy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL dout_unexpected: got %h, required no output", dout);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_err++;
                    $display("FAIL dout: got %h, required %h", dout, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic m);
        key_load = 1'b1;
        key      = KEY;
        iv       = '0;
        mode     = m;
        tick();
        key_load = 1'b0;
        check("key_en_pulse", 192'(core_key_en), 192'(1));
        check("core_key", core_key, KEY);
    endtask

    task automatic wait_rdy(input string name);
        int i;
        i = 0;
        while (!din_rdy && i < 300) begin
            tick();
            i++;
        end
        if (!din_rdy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got din_rdy=0, required 1", name);
        end
    endtask

    task automatic send(input logic [127:0] blk, input logic [127:0] core_in,
                        input bit push, input logic [127:0] expv);
        wait_rdy("send");
        if (push) exp_q.push_back(expv);
        din     = blk;
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
        check("din_en_pulse", 192'(core_din_en), 192'(1));
        check("din_rdy_low", 192'(din_rdy), 192'(0));
        check("core_din", 192'(core_din), 192'(core_in));
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            tick();
            i++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_vld();
        int i;
        i = 0;
        while (!dout_vld && i < 300) begin
            tick();
            i++;
        end
        check("dout_vld_seen", 192'(dout_vld), 192'(1));
    endtask

    initial begin
        rst_n = 1'b0; key_load = 1'b0; key = '0; iv = '0; mode = 1'b0;
        din = '0; din_vld = 1'b0; dout_rdy = 1'b1; key_ok_en = 1'b1;
        core_dout = '0; core_dout_en = 1'b0; core_key_ok = 1'b0;
        repeat (3) tick();
        check("rst_dout", 192'(dout), 192'(0));
        check("rst_vld", 192'(dout_vld), 192'(0));
        check("rst_rdy", 192'(din_rdy), 192'(0));
        check("rst_busy", 192'(busy), 192'(0));
        check("rst_err", 192'(err), 192'(0));
        check("rst_core_key", core_key, 192'(0));
        rst_n = 1'b1;
        tick();

        // Encrypt: two chained blocks give the same ciphertext.
        do_load(1'b1);
        check("busy_key", 192'(busy), 192'(1));
        send(PT, PT, 1, CT);
        check("busy_core", 192'(busy), 192'(1));
        send(CT2, PT, 1, CT);
        drain();
        check("enc_err", 192'(err), 192'(0));
        check("enc_flag", 192'(core_flag), 192'(1));

        // Decrypt the same two ciphertexts.
        do_load(1'b0);
        send(CT, CT, 1, PT);
        send(CT, CT, 1, CT2);
        drain();
        check("dec_flag", 192'(core_flag), 192'(0));
        check("dec_err", 192'(err), 192'(0));

        // Output backpressure for 20 cycles.
        do_load(1'b1);
        dout_rdy = 1'b0;
        send(PT, PT, 1, CT);
        wait_vld();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_dout", 192'(dout), 192'(CT));
            check("bp_rdy", 192'(din_rdy), 192'(0));
        end
        dout_rdy = 1'b1;
        drain();
        tick();
        check("bp_rdy_after", 192'(din_rdy), 192'(1));

        // Reload while the block is in the core; the stale result must flag err.
        do_load(1'b1);
        send(PT, PT, 0, '0);
        do_load(1'b1);
        check("reload_err_clr", 192'(err), 192'(0));
        wait_rdy("reload");
        check("reload_err", 192'(err), 192'(1));
        check("reload_vld", 192'(dout_vld), 192'(0));
        send(PT, PT, 1, CT);
        drain();
        check("reload_err_sticky", 192'(err), 192'(1));

        // Key timeout boundary.
        key_ok_en = 1'b0;
        do_load(1'b1);
        repeat (KEY_TMO) tick();
        check("tmo_err_before", 192'(err), 192'(0));
        check("tmo_busy_before", 192'(busy), 192'(1));
        tick();
        check("tmo_err", 192'(err), 192'(1));
        check("tmo_busy", 192'(busy), 192'(0));
        check("tmo_rdy", 192'(din_rdy), 192'(0));

        // Asynchronous reset mid-session with a pending output.
        key_ok_en = 1'b1;
        do_load(1'b1);
        dout_rdy = 1'b0;
        send(PT, PT, 0, '0);
        wait_vld();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld", 192'(dout_vld), 192'(0));
        check("arst_dout", 192'(dout), 192'(0));
        check("arst_core_key", core_key, 192'(0));
        check("arst_core_din", 192'(core_din), 192'(0));
        check("arst_flag", 192'(core_flag), 192'(0));
        check("arst_busy", 192'(busy), 192'(0));
        repeat (2) tick();
        dout_rdy = 1'b1;
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 192'(busy), 192'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes192_cbc_seq.md
# aes192_cbc_seq

CBC-mode sequencer that sits directly upstream of `aes192_core`. It owns the key/IV session, the chaining XOR and a one-block output register, and converts a valid/ready block stream into the core's key_en/din_en pulse protocol. It supports encryption and decryption and flags protocol faults from the core.

## Interface
- `KEY_TMO`, default 255: cycles allowed for `i_core_key_ok` after key load before the block aborts with an error.
- `i_clk` in 1: clock; all logic is on the rising edge.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_key_load` in 1: one-cycle pulse that starts a new session and samples `i_key`, `i_iv` and `i_mode`.
- `i_key` in 192: session key.
- `i_iv` in 128: initial chaining value.
- `i_mode` in 1: 1 = encrypt, 0 = decrypt.
- `i_din` in 128: input block.
- `i_din_vld` in 1: input block valid.
- `o_din_rdy` out 1: input ready.
- `o_dout` out 128: output block.
- `o_dout_vld` out 1: output valid.
- `i_dout_rdy` in 1: downstream ready.
- `o_core_flag` out 1: core direction, 1 = encrypt.
- `o_core_key` out 192: registered session key to the core.
- `o_core_key_en` out 1: one-cycle key-load pulse to the core.
- `o_core_din` out 128: registered block to the core.
- `o_core_din_en` out 1: one-cycle data pulse to the core.
- `i_core_dout` in 128: core result.
- `i_core_dout_en` in 1: core result strobe.
- `i_core_key_ok` in 1: core key expansion done.
- `o_busy` out 1: high whenever the state is not IDLE or READY.
- `o_err` out 1: sticky error; cleared only by reset or `i_key_load`.

## Operation
- **States:** IDLE, KEY, READY, CORE, OUT.
- **Reset:** state IDLE; every output 0 (including `o_dout`, `o_core_key`, `o_core_din`); chain register 0.
- **IDLE to KEY:** `i_key_load` registers the key, IV (into the chain register) and mode. `o_core_key_en` pulses in the cycle after the load.
- **KEY:**
  - A 2-cycle guard follows the `o_core_key_en` pulse; `i_core_key_ok` is ignored during it.
  - After the guard, `i_core_key_ok` high moves the state to READY.
  - If the timeout counter reaches `KEY_TMO`, set `o_err` and go to IDLE.
- **READY:** `o_din_rdy` = 1. On `i_din_vld & o_din_rdy`:
  - Encrypt: `o_core_din` <= `i_din` ^ chain.
  - Decrypt: `o_core_din` <= `i_din`, and `i_din` is saved into the ct_hold register.
  - Pulse `o_core_din_en` for one cycle and go to CORE.
- **CORE:** wait for `i_core_dout_en`.
  - Encrypt: result = `i_core_dout`; chain <= `i_core_dout`.
  - Decrypt: result = `i_core_dout` ^ chain; chain <= ct_hold.
  - Register the result into `o_dout`, set `o_dout_vld`, go to OUT.
- **OUT:** hold `o_dout` and `o_dout_vld` stable until `i_dout_rdy`. In that cycle, clear `o_dout_vld` and go to READY.
- **`i_key_load` in any state:** it has priority. Abort the current block, drop the pending output (`o_dout_vld` <= 0), clear `o_err`, and restart at KEY with the new parameters.
- **`i_core_dout_en` outside CORE:** set `o_err` and ignore the result; the state is unchanged.
- **Core direction:** `o_core_flag` equals the session mode. It is constant for the whole session, including its value at the `o_core_din_en` pulse.
- **Chain across sessions:** the chain register persists across blocks within a session. A new `i_key_load` reloads it from `i_iv`.

## Timing
- Load pulse at cycle t: `o_core_key_en` is high at t+1; `i_core_key_ok` is first sampled at t+4.
- Input accept at cycle a: `o_core_din_en` is high at a+1; `o_din_rdy` is low from a+1.
- `i_core_dout_en` at cycle c: `o_dout_vld` is high at c+1.
- Output handshake at cycle h: `o_din_rdy` is high at h+1.
- Throughput: one block per (core latency + 3) cycles when `i_dout_rdy` is held high.
- `o_core_key_en` and `o_core_din_en` are never high in the same cycle.
- There are no combinational paths from inputs to outputs.

## Test plan
Key for all tests: 000102030405060708090a0b0c0d0e0f1011121314151617. IV: 0. The real `aes192_core` is connected.

- **Encrypt, block 1:** load with mode=1, send 00112233445566778899aabbccddeeff -> `o_dout` = dda97ca4864cdfe06eaf70a0ec0d7191; `o_err` = 0.
- **Encrypt, block 2 (chaining):** send ddb85e97c219b997e636da1b20d09f6e -> `o_dout` = dda97ca4864cdfe06eaf70a0ec0d7191.
- **Decrypt chain:** load with mode=0, send the two ciphertexts -> outputs 00112233445566778899aabbccddeeff, then ddb85e97c219b997e636da1b20d09f6e.
- **Output backpressure:** hold `i_dout_rdy` = 0 for 20 cycles -> `o_dout` stable, `o_din_rdy` = 0; the block completes after `i_dout_rdy` rises.
- **Mid-block reload:** pulse `i_key_load` while in CORE -> the stale core result is dropped and flags `o_err` (sticky); the next block matches the fresh-IV encrypt result.
- **Reset and timeout:** with `i_core_key_ok` tied low -> `o_err` = 1 after `KEY_TMO` cycles and the state returns to IDLE. Asserting `i_rst_n` low mid-session -> all outputs 0 immediately.
